// File: rtl/i2c_byte_master_if.sv
// Command/status handshake between a requester and the i2c_byte_master bit engine.
interface i2c_byte_master_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] slave_addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              ack_err;

    modport master (output start, rw, slave_addr, wdata, input rdata, busy, done, ack_err);
    modport slave  (input start, rw, slave_addr, wdata, output rdata, busy, done, ack_err);
endinterface

// File: rtl/i2c_byte_master.sv
// Single-transaction I2C master: START, address+R/W, one data byte, ACK/NACK, STOP.
// Advances only on the half-period scl_tick; SCL/SDA are open-drain style outputs.
module i2c_byte_master #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_tick,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_o,
    output logic             sda_o,
    output logic             sda_oe,
    i2c_byte_master_if.slave cmd
);
    localparam int unsigned AB_W  = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_STOP
    } state_t;

    state_t            state_q;
    logic              phase_q;
    logic              upd_q;
    logic              fin_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] wd_q;
    logic              rw_q;
    logic              scl_q;
    logic              sda_q;
    logic              oe_q;
    logic              busy_q;
    logic              done_q;
    logic              ack_err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [AB_W-1:0]   addr_byte;

    assign addr_byte = {cmd.slave_addr, cmd.rw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            upd_q     <= 1'b0;
            fin_q     <= 1'b0;
            cnt_q     <= '0;
            sh_q      <= '0;
            wd_q      <= '0;
            rw_q      <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            upd_q  <= 1'b0;

            // SDA moves one clk after SCL falls to give the slave hold margin
            if (upd_q) begin
                unique case (state_q)
                    S_ADDR, S_WR: begin
                        oe_q  <= 1'b1;
                        sda_q <= sh_q[DATA_W-1];
                    end
                    S_ADDR_ACK, S_WR_ACK, S_RD: begin
                        oe_q  <= 1'b0;
                        sda_q <= 1'b1;
                    end
                    S_RD_ACK: begin
                        oe_q  <= 1'b1;
                        sda_q <= 1'b1;
                    end
                    S_STOP: begin
                        oe_q  <= 1'b1;
                        sda_q <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (fin_q) begin
                fin_q   <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else if (state_q == S_IDLE) begin
                if (cmd.start) begin
                    sh_q      <= DATA_W'(addr_byte);
                    wd_q      <= cmd.wdata;
                    rw_q      <= cmd.rw;
                    busy_q    <= 1'b1;
                    ack_err_q <= 1'b0;
                    phase_q   <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= S_START;
                end
            end else if (scl_tick) begin
                if (!phase_q) begin
                    phase_q <= 1'b1;
                    if (state_q == S_START) begin
                        oe_q  <= 1'b1;
                        sda_q <= 1'b0;
                    end else begin
                        scl_q <= 1'b1;
                    end
                end else if (state_q == S_START) begin
                    phase_q <= 1'b0;
                    scl_q   <= 1'b0;
                    upd_q   <= 1'b1;
                    state_q <= S_ADDR;
                end else if (state_q == S_STOP) begin
                    phase_q <= 1'b0;
                    sda_q   <= 1'b1;
                    oe_q    <= 1'b0;
                    fin_q   <= 1'b1;
                end else if (scl_in) begin
                    // High-to-low half: sample, drop SCL; held off while a slave stretches
                    phase_q <= 1'b0;
                    scl_q   <= 1'b0;
                    upd_q   <= 1'b1;
                    unique case (state_q)
                        S_ADDR, S_WR, S_RD: begin
                            sh_q  <= {sh_q[DATA_W-2:0], sda_in};
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_BIT) begin
                                if (state_q == S_ADDR) begin
                                    state_q <= S_ADDR_ACK;
                                end else if (state_q == S_WR) begin
                                    state_q <= S_WR_ACK;
                                end else begin
                                    rdata_q <= {sh_q[DATA_W-2:0], sda_in};
                                    state_q <= S_RD_ACK;
                                end
                            end
                        end
                        S_ADDR_ACK: begin
                            if (sda_in) begin
                                ack_err_q <= 1'b1;
                                state_q   <= S_STOP;
                            end else if (rw_q) begin
                                state_q <= S_RD;
                            end else begin
                                sh_q    <= wd_q;
                                state_q <= S_WR;
                            end
                        end
                        S_WR_ACK: begin
                            ack_err_q <= sda_in;
                            state_q   <= S_STOP;
                        end
                        S_RD_ACK: state_q <= S_STOP;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign scl_o       = scl_q;
    assign sda_o       = sda_q;
    assign sda_oe      = oe_q;
    assign cmd.rdata   = rdata_q;
    assign cmd.busy    = busy_q;
    assign cmd.done    = done_q;
    assign cmd.ack_err = ack_err_q;
endmodule
